f1_start_ctrl: RTL and testbench

- Sequencer for the F1 start-light FSM (8-step thermometer light bar, advanced by `en`, wraps to all-off on the 9th `en`).
- Generates the light-advance pulses at a fixed period, then holds all lights for a pseudo-random delay.
- Issues the lights-out pulse, then measures driver reaction time in clock cycles and flags jump starts.
- Sits between the top level (trigger, button, display) and the light FSM (drives its `en` and `rst`).

---
 rtl/f1_pkg.sv | 21 ++
 rtl/f1_start_ctrl_lfsr7.sv | 20 ++
 rtl/f1_start_ctrl.sv | 143 ++++++++++++++
 tb/tb_f1_start_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// Holds the FSM state encoding and the LFSR definition.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEQ,
        HOLD,
        REACT
    } state_t;

    localparam logic [6:0] LFSR_SEED  = 7'h01;
    // x^7 + x^3 + 1 : feedback from bits 6 and 2
    localparam logic [6:0] LFSR_TAPS  = 7'b1000100;
    localparam int         NUM_LIGHTS = 8;

    function automatic logic [6:0] lfsr_next(input logic [6:0] q);
        return {q[5:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/f1_start_ctrl_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR used to pick the hold delay.
// Seeded non-zero so it never locks up at 0.
module lfsr7
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] data_out
);

    // advance every cycle regardless of controller state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= LFSR_SEED;
        end else begin
            data_out <= lfsr_next(data_out);
        end
    end

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start sequencer: light pulses, random hold, lights-out and
// reaction timing with jump-start detection.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int LIGHT_PERIOD = 50,
    parameter int TICK_W       = 16,
    parameter int REACT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic               button,
    output logic               light_en,
    output logic               light_clr,
    output logic               busy,
    output logic               react_valid,
    output logic [REACT_W-1:0] react_time,
    output logic               jump_start
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(LIGHT_PERIOD - 1);
    localparam logic [3:0]        LAST_LIGHT = 4'(NUM_LIGHTS - 1);

    state_t             state;
    state_t             nxt;
    logic [TICK_W-1:0]  tick;
    logic [3:0]         lights;
    logic [6:0]         delay;
    logic [6:0]         hold_cnt;
    logic [REACT_W-1:0] react_cnt;
    logic [REACT_W-1:0] react_now;
    logic [6:0]         lfsr;
    logic               tick_end;
    logic               hold_done;

    lfsr7 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .data_out (lfsr)
    );

    assign tick_end  = (tick == TICK_LAST);
    assign hold_done = tick_end && (hold_cnt == (delay - 7'd1));
    assign busy      = (state != IDLE);
    assign react_now = (&react_cnt) ? react_cnt
                                    : react_cnt + REACT_W'(1);

    // next state and the single-cycle strobes to the light FSM
    always_comb begin
        nxt        = state;
        light_en   = 1'b0;
        light_clr  = 1'b0;
        jump_start = 1'b0;
        unique case (state)
            IDLE: begin
                // rst gate keeps light_clr low while reset is held
                if (trigger && rst) begin
                    light_clr = 1'b1;
                    nxt       = SEQ;
                end
            end
            SEQ: begin
                if (button) begin
                    jump_start = 1'b1;
                    light_clr  = 1'b1;
                    nxt        = IDLE;
                end else if (tick_end) begin
                    light_en = 1'b1;
                    if (lights == LAST_LIGHT) begin
                        nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (button) begin
                    jump_start = 1'b1;
                    light_clr  = 1'b1;
                    nxt        = IDLE;
                end else if (hold_done) begin
                    light_en = 1'b1;
                    nxt      = REACT;
                end
            end
            REACT: begin
                if (button) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // state register plus tick, light, hold and reaction counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick        <= '0;
            lights      <= '0;
            delay       <= 7'd1;
            hold_cnt    <= '0;
            react_cnt   <= '0;
            react_time  <= '0;
            react_valid <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt != state || !(state == SEQ || state == HOLD)) begin
                tick <= '0;
            end else if (tick_end) begin
                tick <= '0;
            end else begin
                tick <= tick + TICK_W'(1);
            end

            if (state == IDLE) begin
                lights <= '0;
            end else if (state == SEQ && light_en) begin
                lights <= lights + 4'd1;
            end

            // delay is captured on the cycle of the last light pulse
            if (state == SEQ && nxt == HOLD) begin
                delay    <= lfsr;
                hold_cnt <= '0;
            end else if (state == HOLD && tick_end) begin
                hold_cnt <= hold_cnt + 7'd1;
            end

            if (state == HOLD && nxt == REACT) begin
                react_cnt <= '0;
            end else if (state == REACT) begin
                react_cnt <= react_now;
            end

            react_valid <= (state == REACT) && button;
            if (state == REACT && button) begin
                react_time <= react_now;
            end
        end
    end

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Directed bench for f1_start_ctrl: start, timing, jump starts,
// reaction saturation and asynchronous reset.
module tb_f1_start_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic        button = 1'b0;
    logic        light_en, light_clr, busy, react_valid, jump_start;
    logic [15:0] react_time;

    logic        trigger2 = 1'b0;
    logic        button2 = 1'b0;
    logic        light_en2, light_clr2, busy2, react_valid2, jump_start2;
    logic [3:0]  react_time2;

    logic [6:0]  m_lfsr;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    f1_start_ctrl #(.LIGHT_PERIOD(4), .TICK_W(16), .REACT_W(16)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .button(button),
        .light_en(light_en), .light_clr(light_clr), .busy(busy),
        .react_valid(react_valid), .react_time(react_time),
        .jump_start(jump_start)
    );

    f1_start_ctrl #(.LIGHT_PERIOD(2), .TICK_W(8), .REACT_W(4)) dut2 (
        .clk(clk), .rst(rst), .trigger(trigger2), .button(button2),
        .light_en(light_en2), .light_clr(light_clr2), .busy(busy2),
        .react_valid(react_valid2), .react_time(react_time2),
        .jump_start(jump_start2)
    );

    // reference x^7+x^3+1 sequence, seeded like the design
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 7'h01;
        else      m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
    end

    task automatic drive(input logic t, input logic b);
        @(negedge clk);
        trigger = t;
        button  = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if ({light_en, light_clr, busy, react_valid, jump_start,
                 react_time, light_en2, light_clr2, busy2,
                 react_valid2, jump_start2, react_time2} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got busy=%b react_time=%0d want all 0",
                         k, busy, react_time);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if ({light_en, light_clr, busy, react_valid, jump_start} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_quiet cyc=%0d got %b want 00000", k,
                         {light_en, light_clr, busy, react_valid, jump_start});
            end
        end
    endtask

    task automatic test_full_run();
        logic [6:0] snap;
        int hold_len;
        snap = '0;
        drive(1'b1, 1'b0);
        n_chk++;
        if (light_clr !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clr got clr=%b busy=%b want clr=1 busy=0", light_clr, busy);
        end
        for (int k = 1; k <= 32; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if (light_en !== (k % 4 == 0) || light_clr !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_pulse k=%0d got en=%b clr=%b busy=%b want en=%b clr=0 busy=1",
                         k, light_en, light_clr, busy, (k % 4 == 0));
            end
            if (k == 32) snap = m_lfsr;
        end
        hold_len = 4 * int'(snap);
        for (int k = 1; k <= hold_len; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if (light_en !== (k == hold_len)) begin
                n_fail++;
                $display("FAIL hold_pulse k=%0d/%0d got en=%b want %b",
                         k, hold_len, light_en, (k == hold_len));
            end
        end
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, k == 10);
            n_chk++;
            if (react_valid !== 1'b0 || light_en !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL react_wait k=%0d got valid=%b en=%b busy=%b want 0 0 1",
                         k, react_valid, light_en, busy);
            end
        end
        drive(1'b0, 1'b0);
        n_chk++;
        if (react_valid !== 1'b1 || react_time !== 16'd10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL react_result got valid=%b time=%0d busy=%b want 1 10 0",
                     react_valid, react_time, busy);
        end
        drive(1'b0, 1'b0);
        n_chk++;
        if (react_valid !== 1'b0 || react_time !== 16'd10) begin
            n_fail++;
            $display("FAIL react_hold got valid=%b time=%0d want 0 10",
                     react_valid, react_time);
        end
    endtask

    task automatic test_jump_seq();
        drive(1'b1, 1'b1);
        n_chk++;
        if (light_clr !== 1'b1 || jump_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_trig_btn got clr=%b jump=%b want 1 0", light_clr, jump_start);
        end
        for (int k = 1; k <= 14; k++) begin
            drive(1'b0, k == 14);
            n_chk++;
            if (k < 14) begin
                if (light_en !== (k % 4 == 0) || jump_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL jseq_pulse k=%0d got en=%b jump=%b want %b 0",
                             k, light_en, jump_start, (k % 4 == 0));
                end
            end else if (jump_start !== 1'b1 || light_clr !== 1'b1 || light_en !== 1'b0) begin
                n_fail++;
                $display("FAIL jseq_jump got jump=%b clr=%b en=%b want 1 1 0",
                         jump_start, light_clr, light_en);
            end
        end
        for (int k = 1; k <= 40; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if ({light_en, jump_start, light_clr, busy} !== 4'b0) begin
                n_fail++;
                $display("FAIL jseq_after k=%0d got %b want 0000", k,
                         {light_en, jump_start, light_clr, busy});
            end
        end
        n_chk++;
        if (react_time !== 16'd10) begin
            n_fail++;
            $display("FAIL jseq_time got %0d want 10", react_time);
        end
    endtask

    task automatic test_jump_hold();
        logic [6:0] snap;
        int hold_len;
        snap = '0;
        drive(1'b1, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if (light_en !== (k % 4 == 0)) begin
                n_fail++;
                $display("FAIL jhold_seq k=%0d got en=%b want %b", k, light_en, (k % 4 == 0));
            end
            if (k == 32) snap = m_lfsr;
        end
        hold_len = 4 * int'(snap);
        for (int k = 1; k <= hold_len; k++) begin
            drive(1'b0, k == hold_len);
            n_chk++;
            if (k < hold_len) begin
                if (light_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL jhold_wait k=%0d got en=%b want 0", k, light_en);
                end
            end else if (jump_start !== 1'b1 || light_en !== 1'b0 || light_clr !== 1'b1) begin
                n_fail++;
                $display("FAIL jhold_jump got jump=%b en=%b clr=%b want 1 0 1",
                         jump_start, light_en, light_clr);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if ({busy, light_en, react_valid, jump_start} !== 4'b0 || react_time !== 16'd10) begin
                n_fail++;
                $display("FAIL jhold_after k=%0d got %b time=%0d want 0000 10", k,
                         {busy, light_en, react_valid, jump_start}, react_time);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        drive(1'b1, 1'b0);
        for (int k = 1; k <= 35; k++) begin
            drive(1'b1, 1'b0);
            n_chk++;
            if (light_en !== (k % 4 == 0 && k <= 32) || light_clr !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL trig_held k=%0d got en=%b clr=%b busy=%b want %b 0 1",
                         k, light_en, light_clr, busy, (k % 4 == 0 && k <= 32));
            end
        end
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({light_en, light_clr, busy, react_valid, jump_start} !== 5'b0
            || react_time !== 16'd0) begin
            n_fail++;
            $display("FAIL async_rst got %b time=%0d want 00000 0",
                     {light_en, light_clr, busy, react_valid, jump_start}, react_time);
        end
        @(negedge clk);
        trigger = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        n_chk++;
        if (light_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clr got %b want 1", light_clr);
        end
        for (int k = 1; k <= 36; k++) begin
            drive(1'b0, 1'b0);
            n_chk++;
            if (light_en !== (k % 4 == 0 && k <= 32)) begin
                n_fail++;
                $display("FAIL restart_seq k=%0d got en=%b want %b",
                         k, light_en, (k % 4 == 0 && k <= 32));
            end
        end
    endtask

    task automatic test_saturation();
        int cnt;
        int guard;
        cnt = 0;
        guard = 0;
        @(negedge clk);
        trigger2 = 1'b1;
        #1;
        n_chk++;
        if (light_clr2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_start got clr=%b want 1", light_clr2);
        end
        while (cnt < 9 && guard < 1000) begin
            @(negedge clk);
            trigger2 = 1'b0;
            #1;
            if (light_en2 === 1'b1) cnt++;
            guard++;
        end
        n_chk++;
        if (cnt != 9) begin
            n_fail++;
            $display("FAIL sat_timeout got %0d pulses want 9", cnt);
        end
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            button2 = (k == 21);
            #1;
            n_chk++;
            if (react_valid2 !== 1'b0 || busy2 !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_wait k=%0d got valid=%b busy=%b want 0 1",
                         k, react_valid2, busy2);
            end
        end
        @(negedge clk);
        button2 = 1'b0;
        #1;
        n_chk++;
        if (react_valid2 !== 1'b1 || react_time2 !== 4'd15 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_result got valid=%b time=%0d busy=%b want 1 15 0",
                     react_valid2, react_time2, busy2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_run();
        test_jump_seq();
        test_jump_hold();
        test_reset_mid_hold();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
